// File: rtl/gesture_page_sequencer.sv
// -----------------------------------------------------------------------------
// gesture_page_sequencer
//
// Turns one-cycle West/East swipe pulses from the touch front end into a
// committed page index. Gestures are queued in a small direction FIFO. Each
// popped gesture yields a target page, which is requested from the image
// loader through a req/ack/done handshake. The page is committed only when
// the load completes, and a post-load lockout (HOLD) follows each commit.
//
// Optional feature (compile-time macro GESTURE_PAGE_WRAP_EN):
//   defined   : page indices wrap modulo NUM_PAGES at both ends.
//   undefined : page indices saturate at 0 and NUM_PAGES-1. A gesture that
//               would leave the page unchanged is discarded without a load.
//
// Parameters:
//   NUM_PAGES       number of pages (2..256)
//   PAGE_W          page index width, 2**PAGE_W >= NUM_PAGES
//   FIFO_DEPTH      gesture queue entries, power of 2 (2..16)
//   HOLD_CYCLES     lockout length after each committed load
//   TIMEOUT_CYCLES  longest wait for iLoad_done after iLoad_ack (>= 1)
//
// Ports:
//   iCLK        system clock
//   iRSTN       asynchronous active-low reset
//   iGest_W     one-cycle pulse: previous page
//   iGest_E     one-cycle pulse: next page
//   iClr_err    synchronous clear of oOverflow / oTimeout (a set wins)
//   oLoad_req   load request, held until iLoad_ack
//   oLoad_page  page to load, stable while oLoad_req is high
//   iLoad_ack   loader accepted the request
//   iLoad_done  loader finished (one-cycle pulse)
//   oPage       committed current page
//   oPage_upd   one-cycle pulse when oPage changes
//   oBusy       FSM not idle, or gestures still queued
//   oOverflow   sticky: a gesture was dropped on a full queue
//   oTimeout    sticky: a load timed out waiting for iLoad_done
// -----------------------------------------------------------------------------
module gesture_page_sequencer #(
  parameter int NUM_PAGES      = 8,
  parameter int PAGE_W         = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int HOLD_CYCLES    = 5000000,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic              iCLK,
  input  logic              iRSTN,
  input  logic              iGest_W,
  input  logic              iGest_E,
  input  logic              iClr_err,
  output logic              oLoad_req,
  output logic [PAGE_W-1:0] oLoad_page,
  input  logic              iLoad_ack,
  input  logic              iLoad_done,
  output logic [PAGE_W-1:0] oPage,
  output logic              oPage_upd,
  output logic              oBusy,
  output logic              oOverflow,
  output logic              oTimeout
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  // The shared counter only ever runs 0 .. CNT_MAX-1.
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0]  HOLD_LAST    = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [PAGE_W-1:0] LAST_PAGE    = PAGE_W'(NUM_PAGES - 1);
  localparam logic [AW:0]       FIFO_FULL    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  // A zero-length lockout skips HOLD entirely.
  localparam state_t COMMIT_NEXT = (HOLD_CYCLES == 0) ? S_IDLE : S_HOLD;

  // ---------------------------------------------------------------------------
  // Registers and wires
  // ---------------------------------------------------------------------------
  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_load_req;
  logic [PAGE_W-1:0]   r_load_page;
  logic [PAGE_W-1:0]   r_page;
  logic                r_page_upd;
  logic                r_overflow;
  logic                r_timeout;

  logic                r_fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_count;

  logic                w_gest_valid;
  logic                w_gest_dir;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic                w_head_dir;
  logic [PAGE_W-1:0]   w_target;
  logic                w_timeout_evt;

  // ---------------------------------------------------------------------------
  // Gesture FIFO (one direction bit per entry: W=0, E=1)
  // ---------------------------------------------------------------------------
  // Simultaneous W and E is ambiguous and is ignored outright.
  assign w_gest_valid = iGest_W ^ iGest_E;
  assign w_gest_dir   = iGest_E;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FIFO_FULL);

  // The FSM consumes one entry per cycle while idle.
  assign w_pop  = (r_state == S_IDLE) && !w_empty;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign w_push = w_gest_valid && (!w_full || w_pop);
  assign w_drop = w_gest_valid && w_full && !w_pop;

  assign w_head_dir = r_fifo_mem[r_rd_ptr];

  // NOTE: the storage array has no reset; the pointers and count alone define
  // which entries are valid, so clearing the data bits would buy nothing.
  always_ff @(posedge iCLK) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= w_gest_dir;
    end
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Target page for the entry at the head of the queue, always relative to
  // the committed page.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so that no path
  // through the block leaves it unassigned and infers a latch.
  always_comb begin
    w_target = r_page;
    if (w_head_dir) begin
      if (r_page == LAST_PAGE) begin
`ifdef GESTURE_PAGE_WRAP_EN
        w_target = '0;
`else
        w_target = r_page;
`endif
      end else begin
        w_target = r_page + PAGE_W'(1);
      end
    end else begin
      if (r_page == '0) begin
`ifdef GESTURE_PAGE_WRAP_EN
        w_target = LAST_PAGE;
`else
        w_target = r_page;
`endif
      end else begin
        w_target = r_page - PAGE_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  assign w_timeout_evt = (r_state == S_WAIT) && !iLoad_done && (r_cnt == TIMEOUT_LAST);

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge value of every other register, matching the hardware.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_load_req  <= 1'b0;
      r_load_page <= '0;
      r_page      <= '0;
      r_page_upd  <= 1'b0;
    end else begin
      r_page_upd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A target equal to the current page is dropped here; the next
          // queued entry is then considered on the following cycle.
          if (w_pop && (w_target != r_page)) begin
            r_load_page <= w_target;
            r_load_req  <= 1'b1;
            r_state     <= S_REQ;
          end
        end

        S_REQ: begin
          if (iLoad_ack) begin
            r_load_req <= 1'b0;
            r_cnt      <= '0;
            if (iLoad_done) begin
              // Loader completed in the same cycle it accepted.
              r_page     <= r_load_page;
              r_page_upd <= 1'b1;
              r_state    <= COMMIT_NEXT;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (iLoad_done) begin
            r_page     <= r_load_page;
            r_page_upd <= 1'b1;
            r_cnt      <= '0;
            r_state    <= COMMIT_NEXT;
          end else if (r_cnt == TIMEOUT_LAST) begin
            // Abandon the load; the committed page is left untouched.
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags: a set event in the same cycle as a clear wins.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (iClr_err) begin
        r_overflow <= 1'b0;
      end

      if (w_timeout_evt) begin
        r_timeout <= 1'b1;
      end else if (iClr_err) begin
        r_timeout <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign oLoad_req  = r_load_req;
  assign oLoad_page = r_load_page;
  assign oPage      = r_page;
  assign oPage_upd  = r_page_upd;
  assign oOverflow  = r_overflow;
  assign oTimeout   = r_timeout;
  assign oBusy      = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_gesture_page_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for gesture_page_sequencer.
//
// A reference model predicts the page each accepted gesture should request
// and pushes it to a scoreboard queue; the loader-side tasks pop the queue
// when the DUT raises oLoad_req and compare oLoad_page / oPage against it.
// Build with +define+GESTURE_PAGE_WRAP_EN to exercise the wrap variant.
// -----------------------------------------------------------------------------
module tb_gesture_page_sequencer;

  localparam int NUM_PAGES      = 8;
  localparam int PAGE_W         = 8;
  localparam int FIFO_DEPTH     = 4;
  localparam int HOLD_CYCLES    = 8;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int REQ_WAIT_MAX   = 64;

`ifdef GESTURE_PAGE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic              iCLK = 1'b0;
  logic              iRSTN = 1'b0;
  logic              iGest_W = 1'b0;
  logic              iGest_E = 1'b0;
  logic              iClr_err = 1'b0;
  logic              oLoad_req;
  logic [PAGE_W-1:0] oLoad_page;
  logic              iLoad_ack = 1'b0;
  logic              iLoad_done = 1'b0;
  logic [PAGE_W-1:0] oPage;
  logic              oPage_upd;
  logic              oBusy;
  logic              oOverflow;
  logic              oTimeout;

  gesture_page_sequencer #(
    .NUM_PAGES      (NUM_PAGES),
    .PAGE_W         (PAGE_W),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .iCLK       (iCLK),
    .iRSTN      (iRSTN),
    .iGest_W    (iGest_W),
    .iGest_E    (iGest_E),
    .iClr_err   (iClr_err),
    .oLoad_req  (oLoad_req),
    .oLoad_page (oLoad_page),
    .iLoad_ack  (iLoad_ack),
    .iLoad_done (iLoad_done),
    .oPage      (oPage),
    .oPage_upd  (oPage_upd),
    .oBusy      (oBusy),
    .oOverflow  (oOverflow),
    .oTimeout   (oTimeout)
  );

  always #5 iCLK = ~iCLK;

  int errors = 0;
  int checks = 0;

  // Scoreboard of pages the DUT is expected to request, in order.
  logic [PAGE_W-1:0] exp_q [$];
  int model_tail;       // page after every predicted load has committed
  int model_committed;  // page the DUT should currently show on oPage

  // ---------------------------------------------------------------------------
  // Model and stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic bit model_gesture(input bit east);
    int tgt;
    if (east) begin
      if (model_tail == NUM_PAGES - 1) tgt = WRAP ? 0 : model_tail;
      else                             tgt = model_tail + 1;
    end else begin
      if (model_tail == 0) tgt = WRAP ? NUM_PAGES - 1 : 0;
      else                 tgt = model_tail - 1;
    end
    if (tgt != model_tail) begin
      exp_q.push_back(PAGE_W'(tgt));
      model_tail = tgt;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic pulse_gest(input bit w, input bit e);
    iGest_W = w;
    iGest_E = e;
    tick();
    iGest_W = 1'b0;
    iGest_E = 1'b0;
  endtask

  task automatic do_reset();
    iRSTN      = 1'b0;
    iGest_W    = 1'b0;
    iGest_E    = 1'b0;
    iClr_err   = 1'b0;
    iLoad_ack  = 1'b0;
    iLoad_done = 1'b0;
    exp_q.delete();
    model_tail      = 0;
    model_committed = 0;
    repeat (3) tick();
    iRSTN = 1'b1;
    tick();
  endtask

  // Wait (bounded) for oLoad_req.
  task automatic wait_req(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < REQ_WAIT_MAX; i++) begin
      if (oLoad_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Plays the loader side of one complete transaction against the scoreboard.
  task automatic loader_transaction(input int ack_wait, input bit done_with_ack,
                                    input int done_wait);
    bit                seen;
    logic [PAGE_W-1:0] exp_pg;
    logic [PAGE_W-1:0] prev_pg;
    wait_req(seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL load_req_seen: oLoad_req=%0b after %0d cycles, required 1", oLoad_req, REQ_WAIT_MAX);
      return;
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_req: oLoad_page=%0d requested, required no request", oLoad_page);
      return;
    end
    exp_pg  = exp_q.pop_front();
    prev_pg = PAGE_W'(model_committed);
    checks++;
    if (oLoad_page !== exp_pg) begin
      errors++;
      $display("FAIL load_page: got %0d, required %0d", oLoad_page, exp_pg);
    end
    repeat (ack_wait) tick();
    checks++;
    if (oLoad_req !== 1'b1 || oLoad_page !== exp_pg) begin
      errors++;
      $display("FAIL req_hold: req=%0b page=%0d, required req=1 page=%0d", oLoad_req, oLoad_page, exp_pg);
    end
    iLoad_ack  = 1'b1;
    iLoad_done = done_with_ack;
    tick();
    iLoad_ack  = 1'b0;
    iLoad_done = 1'b0;
    checks++;
    if (oLoad_req !== 1'b0) begin
      errors++;
      $display("FAIL req_drop_after_ack: oLoad_req=%0b, required 0", oLoad_req);
    end
    if (!done_with_ack) begin
      repeat (done_wait) tick();
      checks++;
      if (oPage !== prev_pg) begin
        errors++;
        $display("FAIL page_before_done: oPage=%0d, required %0d", oPage, prev_pg);
      end
      iLoad_done = 1'b1;
      tick();
      iLoad_done = 1'b0;
    end
    checks++;
    if (oPage !== exp_pg || oPage_upd !== 1'b1) begin
      errors++;
      $display("FAIL commit: oPage=%0d upd=%0b, required oPage=%0d upd=1", oPage, oPage_upd, exp_pg);
    end
    model_committed = int'(exp_pg);
    tick();
    checks++;
    if (oPage_upd !== 1'b0) begin
      errors++;
      $display("FAIL upd_one_cycle: oPage_upd=%0d, required 0", oPage_upd);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    iRSTN = 1'b0;
    repeat (3) tick();
    checks++;
    if ({oLoad_req, oLoad_page, oPage, oPage_upd, oBusy, oOverflow, oTimeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%0b lpage=%0d page=%0d upd=%0b busy=%0b ovf=%0b to=%0b, required all 0",
               oLoad_req, oLoad_page, oPage, oPage_upd, oBusy, oOverflow, oTimeout);
    end
    do_reset();
  endtask

  task automatic test_single_e();
    do_reset();
    void'(model_gesture(1'b1));
    pulse_gest(1'b0, 1'b1);  // sampled at edge n+1
    checks++;
    if (oLoad_req !== 1'b0 || oBusy !== 1'b1) begin
      errors++;
      $display("FAIL latency_n1: req=%0b busy=%0b, required req=0 busy=1", oLoad_req, oBusy);
    end
    tick();
    checks++;
    if (oLoad_req !== 1'b1) begin
      errors++;
      $display("FAIL latency_n2: oLoad_req=%0b, required 1", oLoad_req);
    end
    loader_transaction(2, 1'b0, 4);
    // Lockout: still busy shortly before it ends, idle just after.
    repeat (HOLD_CYCLES - 3) tick();
    checks++;
    if (oBusy !== 1'b1) begin
      errors++;
      $display("FAIL hold_busy: oBusy=%0b, required 1", oBusy);
    end
    repeat (3) tick();
    checks++;
    if (oBusy !== 1'b0 || oPage !== PAGE_W'(1)) begin
      errors++;
      $display("FAIL after_hold: busy=%0b page=%0d, required busy=0 page=1", oBusy, oPage);
    end
  endtask

  // Gesture from a settled idle state, then either serve or confirm discard.
  task automatic gesture_and_serve(input bit east);
    repeat (HOLD_CYCLES + 2) tick();
    if (model_gesture(east)) begin
      pulse_gest(!east, east);
      loader_transaction(0, 1'b1, 0);
    end else begin
      pulse_gest(!east, east);
      repeat (3) tick();
      checks++;
      if (oLoad_req !== 1'b0 || oBusy !== 1'b0 || oPage !== PAGE_W'(model_committed)) begin
        errors++;
        $display("FAIL boundary_discard: req=%0b busy=%0b page=%0d, required req=0 busy=0 page=%0d",
                 oLoad_req, oBusy, oPage, model_committed);
      end
    end
  endtask

  task automatic test_boundaries();
    // West from page 0.
    do_reset();
    gesture_and_serve(1'b0);
    // Step up to the last page, then East from the top.
    do_reset();
    for (int i = 0; i < NUM_PAGES - 1; i++) gesture_and_serve(1'b1);
    gesture_and_serve(1'b1);
  endtask

  task automatic test_overflow();
    bit                seen;
    logic [PAGE_W-1:0] exp_pg;
    do_reset();
    void'(model_gesture(1'b1));
    pulse_gest(1'b0, 1'b1);
    wait_req(seen);
    exp_pg = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checks++;
    if (!seen || oLoad_page !== exp_pg) begin
      errors++;
      $display("FAIL ovf_first_req: seen=%0b page=%0d, required seen=1 page=%0d", seen, oLoad_page, exp_pg);
    end
    iLoad_ack = 1'b1;
    tick();
    iLoad_ack = 1'b0;
    // Held in WAIT: six gestures, only FIFO_DEPTH of them fit.
    for (int i = 0; i < 6; i++) begin
      if (i < FIFO_DEPTH) void'(model_gesture(1'b1));
      pulse_gest(1'b0, 1'b1);
    end
    checks++;
    if (oOverflow !== 1'b1 || oBusy !== 1'b1 || oLoad_req !== 1'b0) begin
      errors++;
      $display("FAIL overflow_set: ovf=%0b busy=%0b req=%0b, required ovf=1 busy=1 req=0", oOverflow, oBusy, oLoad_req);
    end
    // Clear coinciding with another drop: set wins.
    iClr_err = 1'b1;
    pulse_gest(1'b0, 1'b1);
    iClr_err = 1'b0;
    checks++;
    if (oOverflow !== 1'b1) begin
      errors++;
      $display("FAIL set_wins_clear: oOverflow=%0b, required 1", oOverflow);
    end
    iClr_err = 1'b1;
    tick();
    iClr_err = 1'b0;
    checks++;
    if (oOverflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: oOverflow=%0b, required 0", oOverflow);
    end
    iLoad_done = 1'b1;
    tick();
    iLoad_done = 1'b0;
    checks++;
    if (oPage !== exp_pg || oPage_upd !== 1'b1) begin
      errors++;
      $display("FAIL ovf_first_commit: page=%0d upd=%0b, required page=%0d upd=1", oPage, oPage_upd, exp_pg);
    end
    model_committed = int'(exp_pg);
    loader_transaction(0, 1'b1, 0);
    for (int i = 1; i < FIFO_DEPTH; i++) loader_transaction(1, 1'b0, 2);
    repeat (HOLD_CYCLES + 2) tick();
    checks++;
    if (oPage !== PAGE_W'(5) || oBusy !== 1'b0 || oOverflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_final: page=%0d busy=%0b ovf=%0b, required page=5 busy=0 ovf=0", oPage, oBusy, oOverflow);
    end
  endtask

  task automatic test_both_pulses();
    do_reset();
    pulse_gest(1'b1, 1'b1);
    repeat (3) tick();
    checks++;
    if (oBusy !== 1'b0 || oLoad_req !== 1'b0 || oOverflow !== 1'b0 || oTimeout !== 1'b0) begin
      errors++;
      $display("FAIL both_ignored: busy=%0b req=%0b ovf=%0b to=%0b, required all 0", oBusy, oLoad_req, oOverflow, oTimeout);
    end
  endtask

  task automatic test_timeout();
    bit seen;
    do_reset();
    void'(model_gesture(1'b1));
    pulse_gest(1'b0, 1'b1);
    wait_req(seen);
    checks++;
    if (!seen || oLoad_page !== PAGE_W'(1)) begin
      errors++;
      $display("FAIL to_req: seen=%0b page=%0d, required seen=1 page=1", seen, oLoad_page);
    end
    exp_q.delete();
    model_tail = model_committed;
    iLoad_ack = 1'b1;
    tick();  // ack edge
    iLoad_ack = 1'b0;
    repeat (TIMEOUT_CYCLES - 1) tick();
    checks++;
    if (oTimeout !== 1'b0 || oBusy !== 1'b1) begin
      errors++;
      $display("FAIL to_early: oTimeout=%0b busy=%0b, required to=0 busy=1", oTimeout, oBusy);
    end
    tick();
    checks++;
    if (oTimeout !== 1'b1 || oPage !== '0 || oBusy !== 1'b0 || oLoad_req !== 1'b0) begin
      errors++;
      $display("FAIL to_fire: to=%0b page=%0d busy=%0b req=%0b, required to=1 page=0 busy=0 req=0",
               oTimeout, oPage, oBusy, oLoad_req);
    end
    // Late ack/done while idle must be ignored.
    iLoad_done = 1'b1;
    iLoad_ack  = 1'b1;
    tick();
    iLoad_done = 1'b0;
    iLoad_ack  = 1'b0;
    checks++;
    if (oPage !== '0 || oPage_upd !== 1'b0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL stray_done: page=%0d upd=%0b busy=%0b, required page=0 upd=0 busy=0", oPage, oPage_upd, oBusy);
    end
    iClr_err = 1'b1;
    tick();
    iClr_err = 1'b0;
    checks++;
    if (oTimeout !== 1'b0) begin
      errors++;
      $display("FAIL to_clear: oTimeout=%0b, required 0", oTimeout);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    void'(model_gesture(1'b1)); pulse_gest(1'b0, 1'b1);
    void'(model_gesture(1'b1)); pulse_gest(1'b0, 1'b1);
    void'(model_gesture(1'b1)); pulse_gest(1'b0, 1'b1);
    void'(model_gesture(1'b0)); pulse_gest(1'b1, 1'b0);
    loader_transaction(0, 1'b1, 0);
    loader_transaction(3, 1'b0, 1);
    loader_transaction(1, 1'b1, 0);
    loader_transaction(0, 1'b0, 5);
    checks++;
    if (oPage !== PAGE_W'(2)) begin
      errors++;
      $display("FAIL b2b_final: oPage=%0d, required 2", oPage);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    void'(model_gesture(1'b1));
    pulse_gest(1'b0, 1'b1);
    wait_req(seen);
    for (int i = 0; i < 3; i++) pulse_gest(1'b0, 1'b1);
    checks++;
    if (!seen || oLoad_req !== 1'b1 || oBusy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: seen=%0b req=%0b busy=%0b, required all 1", seen, oLoad_req, oBusy);
    end
    #2;
    iRSTN = 1'b0;
    #1;
    checks++;
    if (oLoad_req !== 1'b0 || oBusy !== 1'b0 || oPage !== '0 || oLoad_page !== '0) begin
      errors++;
      $display("FAIL rst_async: req=%0b busy=%0b page=%0d lpage=%0d, required all 0", oLoad_req, oBusy, oPage, oLoad_page);
    end
    tick();
    iRSTN = 1'b1;
    exp_q.delete();
    model_tail      = 0;
    model_committed = 0;
    repeat (4) tick();
    checks++;
    if (oLoad_req !== 1'b0 || oBusy !== 1'b0 || oPage !== '0) begin
      errors++;
      $display("FAIL rst_flushed: req=%0b busy=%0b page=%0d, required all 0", oLoad_req, oBusy, oPage);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single_e();
    test_boundaries();
    test_overflow();
    test_both_pulses();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gesture_page_sequencer.md
Name: gesture_page_sequencer

Overview:
- Consumes the one-cycle West/East gesture pulses from the MTL touch front end (oGest_W/oGest_E) and turns them into a current slide/page index.
- Queues gestures and requests an image load for each target page from the image-transfer loader through a req/ack/done handshake.
- Commits the page only once the load completes, then enforces a post-load lockout.
- Sits between mtl_touch and the image-transfer/display-buffer loader.

Parameters:
- NUM_PAGES, 8, number of pages; legal range 2..256.
- PAGE_W, 8, width of page index outputs; must satisfy 2^PAGE_W >= NUM_PAGES.
- FIFO_DEPTH, 4, gesture queue entries; power of 2, 2..16.
- HOLD_CYCLES, 5000000, lockout after each committed load (0.1 s at 50 MHz).
- TIMEOUT_CYCLES, 50000000, maximum wait for iLoad_done after ack (1 s).

Ports:
- iCLK  in  1  system clock, 50 MHz.
- iRSTN  in  1  asynchronous active-low reset.
- iGest_W  in  1  one-cycle pulse: previous page.
- iGest_E  in  1  one-cycle pulse: next page.
- iClr_err  in  1  synchronous clear of the sticky flags.
- oLoad_req  out  1  load request, held until ack.
- oLoad_page  out  PAGE_W  page to load; stable while oLoad_req=1.
- iLoad_ack  in  1  loader accepted the request.
- iLoad_done  in  1  loader finished; one-cycle pulse.
- oPage  out  PAGE_W  committed current page.
- oPage_upd  out  1  one-cycle pulse when oPage changes.
- oBusy  out  1  FSM not in IDLE, or FIFO not empty.
- oOverflow  out  1  sticky: a gesture was dropped because the FIFO was full.
- oTimeout  out  1  sticky: a load timed out.

Behaviour:
- Reset (iRSTN=0, asynchronous): all outputs 0, FIFO empty, FSM in IDLE, counters 0, target page 0.
- Enqueue:
  - On the clock edge where exactly one of iGest_W/iGest_E is 1, push one direction bit (W=0, E=1).
  - Both asserted in the same cycle: neither is enqueued and no flag is set.
- FIFO full:
  - A push with no pop in the same cycle is dropped and sets oOverflow.
  - A push and a pop in the same cycle both succeed; occupancy is unchanged.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE, FIFO non-empty:
  - Pop one entry and compute target = oPage+1 (E) or oPage-1 (W), with the boundary rule from the optional feature.
  - If target == oPage, discard the entry and stay in IDLE; the next entry may be popped on the following cycle.
  - Otherwise register target into oLoad_page and go to REQ.
- REQ:
  - oLoad_req=1; oLoad_page held constant.
  - On iLoad_ack=1: deassert oLoad_req next cycle and go to WAIT.
  - If iLoad_done=1 in the same cycle as ack, go straight to the commit action below.
- WAIT:
  - Count cycles.
  - On iLoad_done: oPage <= oLoad_page, oPage_upd=1 for one cycle, go to HOLD.
  - If the count reaches TIMEOUT_CYCLES without done: set oTimeout, leave oPage unchanged, go to IDLE (no hold).
- HOLD:
  - Count HOLD_CYCLES, then go to IDLE.
  - Gestures keep queueing during HOLD; they are not dropped.
- Latency: from a gesture pulse sampled in cycle n with IDLE and empty FIFO, oLoad_req=1 in cycle n+2.
- Dequeue order is strictly FIFO; every target is computed from the committed oPage at pop time.
- iLoad_ack/iLoad_done outside REQ/WAIT are ignored.
- iClr_err clears oOverflow and oTimeout; if a set event occurs in the same cycle, set wins.
- iRSTN asserted mid-transaction aborts immediately: oLoad_req drops asynchronously and the FIFO is flushed.

Optional Feature:
- Macro: GESTURE_PAGE_WRAP_EN.
- Defined: indices wrap modulo NUM_PAGES; E from NUM_PAGES-1 targets 0, W from 0 targets NUM_PAGES-1.
- Undefined: indices saturate; E at NUM_PAGES-1 and W at 0 give target == oPage, so the gesture is discarded with no request.

Test Plan:
- Reset, then one iGest_E pulse at cycle 10 → oLoad_req=1 at cycle 12 with oLoad_page=1; ack at 15, done at 20 → oPage=1, one oPage_upd pulse, oBusy=0 after HOLD.
- Starting at oPage=0, iGest_W pulse → with WRAP_EN: request page 7; without: no oLoad_req, oPage stays 0.
- FIFO_DEPTH=4, FSM held in WAIT, 6 E pulses → 4 queued, oOverflow=1; after completion oPage advances by 5 total (1 in flight + 4 queued).
- iGest_W and iGest_E asserted in the same cycle → no enqueue, oBusy stays 0, flags stay 0.
- Ack given, done withheld, TIMEOUT_CYCLES=100 → oTimeout=1 at 100 cycles after ack, oPage unchanged, FSM in IDLE; iClr_err → oTimeout=0.
- iRSTN pulsed low while oLoad_req=1 with 3 entries queued → oLoad_req=0 immediately, FIFO empty, oPage=0.
